// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch / prefetch stage.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc_plus_1;
  } fetch_entry_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch stage bus: memory instruction port on one side, IF/ID feed and control on the other.
interface fetch_prefetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int OCC_W   = 3
);
  logic [ADDR_W-1:0]  i_addr;
  logic               i_req;
  logic               i_rdy;
  logic [INSTR_W-1:0] i_instr;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               stall;
  logic               hlt;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_plus_1_out;
  logic               valid_out;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output i_addr, i_req,
    input  i_rdy, i_instr,
    input  redirect, redirect_pc, stall, hlt,
    output instr_out, pc_plus_1_out, valid_out, occupancy
  );

  modport slave (
    input  i_addr, i_req,
    output i_rdy, i_instr,
    output redirect, redirect_pc, stall, hlt,
    input  instr_out, pc_plus_1_out, valid_out, occupancy
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; clear wins over push/pop, head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clear,
  input  entry_t               wdata,
  output entry_t               rdata,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch PC, memory request logic and prefetch queue feeding IF/ID.
// Optional same-cycle bypass of an empty queue: define FETCH_BYPASS_EN.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter int               INSTR_W  = INSTR_W_DEF,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input logic                 clk,
  input logic                 rst_n,
  fetch_prefetch_unit_if.master bus
);
  localparam int CNT_W = occ_width(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus_1;
  } entry_t;

  logic [ADDR_W-1:0] fpc_q, fpc_d, fpc_inc;
  logic              full, empty;
  logic              req, enq, push, pop;
  logic [CNT_W-1:0]  count;
  entry_t            wr_entry, head;

  assign fpc_inc  = fpc_q + ADDR_W'(1);
  assign wr_entry = '{instr: bus.i_instr, pc_plus_1: fpc_inc};

  // rst_n gating keeps the request low for the whole reset window
  assign req  = rst_n & ~full & ~bus.hlt & ~bus.redirect;
  assign enq  = req & bus.i_rdy;
  assign pop  = ~empty & ~bus.stall & ~bus.redirect;

  always_comb begin
    fpc_d = fpc_q;
    if (bus.redirect)  fpc_d = bus.redirect_pc;
    else if (enq)      fpc_d = fpc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fpc_q <= RESET_PC;
    else        fpc_q <= fpc_d;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (bus.redirect),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp  = empty & enq;
  // A bypassed word that decode takes this cycle never lands in the queue
  assign push = enq & ~(byp & ~bus.stall);
  assign bus.valid_out     = ~empty | byp;
  assign bus.instr_out     = byp ? bus.i_instr : head.instr;
  assign bus.pc_plus_1_out = byp ? fpc_inc     : head.pc_plus_1;
`else
  assign push = enq;
  assign bus.valid_out     = ~empty;
  assign bus.instr_out     = head.instr;
  assign bus.pc_plus_1_out = head.pc_plus_1;
`endif

  assign bus.i_addr    = fpc_q;
  assign bus.i_req     = req;
  assign bus.occupancy = count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit against a queue-based reference model.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if #(.ADDR_W(16), .INSTR_W(16), .OCC_W(3)) bus ();

  fetch_prefetch_unit #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .DEPTH   (DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pcp1;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_fpc;
  int          total = 0;
  int          bad   = 0;
  logic        hlt_r = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare settled outputs, then advance the model
  task automatic cycle(input logic rdy, input logic stl, input logic hl,
                       input logic rd, input logic [15:0] rpc);
    logic        m_req, m_enq, m_byp, m_pop;
    logic [15:0] w;
    logic [15:0] e_instr, e_pcp1;
    logic        e_valid;
    @(negedge clk);
    w               = 16'($urandom);
    bus.i_rdy       = rdy;
    bus.stall       = stl;
    bus.hlt         = hl;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.i_instr     = w;
    #1;
    m_req = (mq.size() < DEPTH) && !hl && !rd;
    m_enq = m_req && rdy;
    m_byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    m_byp = (mq.size() == 0) && m_enq;
`endif
    if (m_byp) begin
      e_valid = 1'b1; e_instr = w; e_pcp1 = m_fpc + 16'd1;
    end else if (mq.size() != 0) begin
      e_valid = 1'b1; e_instr = mq[0].instr; e_pcp1 = mq[0].pcp1;
    end else begin
      e_valid = 1'b0; e_instr = '0; e_pcp1 = '0;
    end
    check("i_addr", bus.i_addr, m_fpc);
    check("i_req", bus.i_req, m_req);
    check("valid_out", bus.valid_out, e_valid);
    check("instr_out", bus.instr_out, e_instr);
    check("pc_plus_1_out", bus.pc_plus_1_out, e_pcp1);
    check("occupancy", bus.occupancy, mq.size());
    if (rd) begin
      mq.delete();
      m_fpc = rpc;
    end else begin
      m_pop = (mq.size() != 0) && !stl;
      if (m_pop) void'(mq.pop_front());
      if (m_enq) begin
        if (!(m_byp && !stl)) mq.push_back('{instr: w, pcp1: m_fpc + 16'd1});
        m_fpc = m_fpc + 16'd1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_i_addr"}, bus.i_addr, RST_PC);
    check({tag, "_i_req"}, bus.i_req, 1'b0);
    check({tag, "_valid"}, bus.valid_out, 1'b0);
    check({tag, "_instr"}, bus.instr_out, 16'h0);
    check({tag, "_pcp1"}, bus.pc_plus_1_out, 16'h0);
    check({tag, "_occ"}, bus.occupancy, 3'd0);
  endtask

  task automatic idle_inputs();
    bus.i_rdy = 1'b0; bus.stall = 1'b0; bus.hlt = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.i_instr = '0;
  endtask

  task automatic random_run(input int n, input int p_rdy, input int p_stall,
                            input int p_hlt_tog, input int p_redir);
    logic [15:0] rpc;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < p_hlt_tog) hlt_r = ~hlt_r;
      case ($urandom_range(0, 3))
        0:       rpc = 16'hFFFF;
        1:       rpc = 16'hFFFE;
        2:       rpc = 16'h0040;
        default: rpc = 16'($urandom);
      endcase
      cycle($urandom_range(0, 99) < p_rdy, $urandom_range(0, 99) < p_stall, hlt_r,
            $urandom_range(0, 99) < p_redir, rpc);
    end
    hlt_r = 1'b0;
  endtask

  initial begin
    idle_inputs();
    m_fpc = RST_PC;
    #2;
    check_reset_outputs("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // streaming fetch, no back-pressure
    repeat (6) cycle(1, 0, 0, 0, 16'h0);
    // fill under stall, then drain and refill
    repeat (6) cycle(1, 1, 0, 0, 16'h0);
    repeat (6) cycle(1, 0, 0, 0, 16'h0);
    // redirect with three entries queued and a word returning
    cycle(0, 1, 0, 1, 16'h0100);
    repeat (3) cycle(1, 1, 0, 0, 16'h0);
    cycle(1, 1, 0, 1, 16'h0040);
    repeat (4) cycle(1, 0, 0, 0, 16'h0);
    // halt with two queued entries draining
    cycle(0, 1, 0, 1, 16'h0200);
    repeat (2) cycle(1, 1, 0, 0, 16'h0);
    repeat (5) cycle(1, 0, 1, 0, 16'h0);
    cycle(1, 0, 1, 1, 16'h0300);
    repeat (3) cycle(1, 0, 0, 0, 16'h0);
    // address wrap with wait states
    cycle(0, 1, 0, 1, 16'hFFFF);
    cycle(0, 1, 0, 0, 16'h0);
    cycle(0, 1, 0, 0, 16'h0);
    cycle(1, 1, 0, 0, 16'h0);
    cycle(1, 1, 0, 0, 16'h0);
    repeat (3) cycle(1, 0, 0, 0, 16'h0);

    random_run(1500, 70, 30, 6, 5);
    random_run(800, 95, 70, 2, 2);
    random_run(800, 40, 10, 10, 8);

    // asynchronous reset with three entries queued
    cycle(0, 1, 0, 1, 16'h0500);
    repeat (3) cycle(1, 1, 0, 0, 16'h0);
    @(negedge clk);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    mq.delete();
    m_fpc = RST_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle(1, 0, 0, 0, 16'h0);
    random_run(400, 70, 40, 5, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
